// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF-path, MEM-path and memory-port signals of mem_port_arbiter.
// The arbiter uses slave and the requesters/memory model use master. No storage, no flow control of its own.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        owner;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_done, d_rdata, d_done, mem_addr, mem_wdata, mem_we, busy, owner
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_done, d_rdata, d_done, mem_addr, mem_wdata, mem_we, busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between IF and MEM. Each access takes LATENCY+2 cycles (IDLE, ACCESS x LATENCY, RESP).
// Requesters hold req until their done pulse. DATA wins ties unless MEM_ARB_ROUND_ROBIN_EN alternates them.
module mem_port_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst_b,
    mem_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_owner;
    logic          r_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [31:0]   r_i_rdata;
    logic [31:0]   r_d_rdata;

    logic          w_any_req;
    logic          w_grant_d;
    logic          w_grant;
    logic          w_access_end;
    logic [31:0]   w_req_addr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic          r_last_owner;

    // On a tie the requester that did not own the previous access wins.
    always_comb begin
        w_grant_d = bus.d_req;
        if (bus.d_req && bus.i_req) begin
            w_grant_d = ~r_last_owner;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_last_owner <= 1'b0;
        end else if (r_state == ST_RESP) begin
            r_last_owner <= r_owner;
        end
    end
`else
    always_comb begin
        w_grant_d = bus.d_req;
    end
`endif

    assign w_any_req    = bus.d_req | bus.i_req;
    assign w_grant      = (r_state == ST_IDLE) && w_any_req;
    assign w_access_end = (r_state == ST_ACCESS) && (r_cnt == '0);
    assign w_req_addr   = w_grant_d ? bus.d_addr : bus.i_addr;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = CW'(LATENCY - 1);
                end
            end
            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // The memory-side address/data registers only move on a grant, so they hold between accesses.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            if (w_grant) begin
                r_owner    <= w_grant_d;
                r_we       <= w_grant_d & bus.d_we;
                r_mem_addr <= w_req_addr & ~32'h3;
                if (w_grant_d) begin
                    r_mem_wdata <= bus.d_wdata;
                end
            end
            if (w_access_end && !r_we) begin
                if (r_owner) begin
                    r_d_rdata <= bus.mem_rdata;
                end else begin
                    r_i_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    // Decoded from state so an asynchronous reset drops the write strobe at once.
    assign bus.mem_we    = w_access_end & r_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_done    = (r_state == ST_RESP) & ~r_owner;
    assign bus.d_done    = (r_state == ST_RESP) &  r_owner;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.owner     = r_owner;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: LATENCY=4 instance (a) and LATENCY=1 instance (b), scoreboarded done pulses.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if a_if();
    mem_port_arbiter_if b_if();

    mem_port_arbiter #(.LATENCY(4)) u_dut_a (.clk(clk), .rst_b(rst_b), .bus(a_if.slave));
    mem_port_arbiter #(.LATENCY(1)) u_dut_b (.clk(clk), .rst_b(rst_b), .bus(b_if.slave));

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0100: rom = 32'hDEAD_BEEF;
            32'h0000_0200: rom = 32'hCAFE_0200;
            32'h0000_0300: rom = 32'h0BAD_0300;
            32'h0000_0400: rom = 32'h4444_0400;
            32'h0000_0500: rom = 32'h5555_0500;
            32'h0000_0010: rom = 32'h1111_0010;
            32'h0000_0014: rom = 32'h2222_0014;
            default:       rom = 32'h0BAD_F00D;
        endcase
    endfunction

    assign a_if.mem_rdata = rom(a_if.mem_addr);
    assign b_if.mem_rdata = rom(b_if.mem_addr);

    typedef struct {
        bit          who;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb_q [2][$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    bit          i_seen = 1'b0;
    bit          d_seen = 1'b0;
    bit          hold = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_if.mem_we) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= a_if.mem_addr;
            wr_data <= a_if.mem_wdata;
        end
    end

    task automatic push(input int p, input bit who, input logic [31:0] data, input int c);
        exp_t e;
        e.who  = who;
        e.data = data;
        e.cyc  = c;
        sb_q[p].push_back(e);
    endtask

    task automatic check_port(input int p, input logic idone, input logic ddone,
                              input logic [31:0] irdata, input logic [31:0] drdata);
        exp_t        e;
        logic [31:0] got;
        if (idone || ddone) begin
            n_cmp++;
            got = ddone ? drdata : irdata;
            if (sb_q[p].size() == 0) begin
                n_fail++;
                $display("FAIL port%0d unexpected_done: got i_done=%b d_done=%b at cyc %0d, required no done", p, idone, ddone, cyc);
            end else begin
                e = sb_q[p].pop_front();
                if ((idone && ddone) || (ddone != e.who) || (cyc != e.cyc) || (got !== e.data)) begin
                    n_fail++;
                    $display("FAIL port%0d done: got d_owner=%b i_done=%b cyc=%0d rdata=%h, required d_owner=%b cyc=%0d rdata=%h",
                             p, ddone, idone, cyc, got, e.who, e.cyc, e.data);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        check_port(0, a_if.i_done, a_if.d_done, a_if.i_rdata, a_if.d_rdata);
        check_port(1, b_if.i_done, b_if.d_done, b_if.i_rdata, b_if.d_rdata);
        i_seen = a_if.i_done;
        d_seen = a_if.d_done;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Requesters on instance a drop req on the edge that ends their done cycle.
    task automatic step();
        @(posedge clk);
        #1;
        if (i_seen && !hold) a_if.i_req = 1'b0;
        if (d_seen && !hold) a_if.d_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((a_if.i_req || a_if.d_req || a_if.busy) && n < 40) begin
            step();
            n++;
        end
        n_cmp++;
        if (n >= 40) begin
            n_fail++;
            $display("FAIL %s_timeout: got still busy after %0d cycles, required idle", name, n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no summary by 100us, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int wr_before;
        a_if.i_req = 0; a_if.i_addr = '0; a_if.d_req = 0; a_if.d_we = 0;
        a_if.d_addr = '0; a_if.d_wdata = '0;
        b_if.i_req = 0; b_if.i_addr = '0; b_if.d_req = 0; b_if.d_we = 0;
        b_if.d_addr = '0; b_if.d_wdata = '0;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", a_if.busy, 0);
        chk("rst_owner", a_if.owner, 0);
        chk("rst_mem_we", a_if.mem_we, 0);
        chk("rst_mem_addr", a_if.mem_addr, 0);
        chk("rst_mem_wdata", a_if.mem_wdata, 0);
        chk("rst_i_rdata", a_if.i_rdata, 0);
        chk("rst_d_rdata", a_if.d_rdata, 0);
        chk("rst_dones", {a_if.i_done, a_if.d_done}, 0);
        rst_b = 1'b1;

        // Simultaneous requests: DATA write first, then the instruction read.
        step();
        t = cyc;
        a_if.i_addr = 32'h200; a_if.d_we = 1; a_if.d_addr = 32'h2004; a_if.d_wdata = 32'h1234_5678;
        a_if.i_req = 1; a_if.d_req = 1;
        push(0, 1'b1, 32'h0, t + 5);
        push(0, 1'b0, 32'hCAFE_0200, t + 11);
        for (int k = 1; k <= 11; k++) begin
            step();
            chk($sformatf("tie_mem_we_k%0d", k), a_if.mem_we, (k == 4) ? 1 : 0);
            if (k == 1) chk("tie_owner_d", {a_if.busy, a_if.owner}, 2'b11);
            if (k == 4) chk("tie_mem_addr_w", a_if.mem_addr, 32'h2004);
            if (k == 4) chk("tie_mem_wdata", a_if.mem_wdata, 32'h1234_5678);
            if (k == 7) chk("tie_owner_i", {a_if.busy, a_if.owner}, 2'b10);
            if (k == 7) chk("tie_mem_addr_i", a_if.mem_addr, 32'h200);
        end
        wait_idle("tie");
        a_if.d_we = 0;
        chk("tie_wr_cnt", wr_cnt, 1);
        chk("tie_wr_addr", wr_addr, 32'h2004);
        chk("tie_wr_data", wr_data, 32'h1234_5678);

        // Both requests held continuously.
        step();
        t = cyc;
        a_if.d_addr = 32'h400; a_if.i_addr = 32'h500;
        hold = 1'b1;
        a_if.i_req = 1; a_if.d_req = 1;
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            push(0, (k % 2) == 0, ((k % 2) == 0) ? 32'h4444_0400 : 32'h5555_0500, t + 5 + 6 * k);
`else
            push(0, 1'b1, 32'h4444_0400, t + 5 + 6 * k);
`endif
        end
        repeat (35) step();
        hold = 1'b0;
        step();
        a_if.i_req = 0; a_if.d_req = 0;
        wait_idle("hold");

        // Lone instruction read.
        step();
        t = cyc;
        a_if.i_addr = 32'h100; a_if.i_req = 1;
        push(0, 1'b0, 32'hDEAD_BEEF, t + 5);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("ird_mem_we_k%0d", k), a_if.mem_we, 0);
            if (k == 2) chk("ird_mem_addr", a_if.mem_addr, 32'h100);
        end
        wait_idle("ird");

        // Unaligned data read.
        step();
        t = cyc;
        a_if.d_we = 0; a_if.d_addr = 32'h303; a_if.d_req = 1;
        push(0, 1'b1, 32'h0BAD_0300, t + 5);
        step();
        chk("drd_mem_addr", a_if.mem_addr, 32'h300);
        wait_idle("drd");
        chk("drd_i_rdata_kept", a_if.i_rdata, 32'hDEAD_BEEF);

        // Reset during the final ACCESS cycle of a write.
        step();
        wr_before = wr_cnt;
        a_if.d_we = 1; a_if.d_addr = 32'h600; a_if.d_wdata = 32'h6666_6666; a_if.d_req = 1;
        repeat (4) step();
        chk("rstw_mem_we_pre", a_if.mem_we, 1);
        #2 rst_b = 1'b0;
        #1;
        chk("rstw_mem_we", a_if.mem_we, 0);
        chk("rstw_busy", a_if.busy, 0);
        chk("rstw_d_done", a_if.d_done, 0);
        chk("rstw_d_rdata", a_if.d_rdata, 0);
        a_if.d_req = 0; a_if.d_we = 0;
        @(negedge clk);
        rst_b = 1'b1;
        step();
        t = cyc;
        a_if.i_addr = 32'h100; a_if.i_req = 1;
        push(0, 1'b0, 32'hDEAD_BEEF, t + 5);
        wait_idle("rstw");
        chk("rstw_no_write", wr_cnt, wr_before);

        // LATENCY=1 back-to-back reads on instance b.
        step();
        t = cyc;
        b_if.d_addr = 32'h10; b_if.d_req = 1;
        push(1, 1'b1, 32'h1111_0010, t + 2);
        push(1, 1'b1, 32'h2222_0014, t + 5);
        step();
        chk("l1_mem_addr0", b_if.mem_addr, 32'h10);
        chk("l1_busy", b_if.busy, 1);
        step();
        step();
        b_if.d_addr = 32'h14;
        step();
        chk("l1_mem_addr1", b_if.mem_addr, 32'h14);
        step();
        step();
        b_if.d_req = 0;
        step();
        chk("l1_idle", b_if.busy, 0);

        repeat (3) step();
        chk("sb_a_drained", sb_q[0].size(), 0);
        chk("sb_b_drained", sb_q[1].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported main memory between the instruction-fetch path and the MEM-stage data/cache path (refills, write-backs, uncached accesses).
- Accepts one word access at a time from either requester, drives the memory port for a fixed access latency, and returns read data plus a one-cycle completion pulse to the winning requester.
- Sits between the IF/MEM stages and the memory model; the pipeline stalls on a pending request until its done pulse.

Parameters:
- LATENCY, 4, memory access cycles per word; legal range is 1 or greater.

Ports:
- clk  in  1  system clock, rising edge
- rst_b  in  1  asynchronous active-low reset
- i_req  in  1  instruction read request, held until i_done
- i_addr  in  32  instruction byte address
- i_rdata  out  32  instruction read data
- i_done  out  1  instruction access complete, one-cycle pulse
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  data write word
- d_rdata  out  32  data read data
- d_done  out  1  data access complete, one-cycle pulse
- mem_addr  out  32  memory word address
- mem_wdata  out  32  memory write word
- mem_we  out  1  memory write enable
- mem_rdata  in  32  memory read word
- busy  out  1  access in flight
- owner  out  1  current owner: 0 = instruction, 1 = data; meaningful only while busy

Behaviour:
- Clock and reset: one clock, clk. rst_b is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - All outputs are 0: busy, owner, i_done, d_done, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata.
  - last_owner is 0 (instruction).
- Reset mid-operation: the in-flight access is dropped, mem_we falls immediately, and no done pulse is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled only in this state.
  - If d_req is high, grant DATA. Otherwise, if i_req is high, grant INST. Otherwise stay in IDLE.
  - On a grant, latch addr, we and wdata into internal registers, set owner, load the counter with LATENCY-1, and go to ACCESS.
- ACCESS:
  - mem_addr is the latched address with bits [1:0] forced to 0.
  - mem_wdata is the latched wdata.
  - mem_we is 1 only in the final ACCESS cycle (counter == 0), and only if the latched we is 1. Instruction grants never write.
  - Each cycle the counter decrements. At counter == 0 the block captures mem_rdata into the owner's rdata register (reads only) and goes to RESP.
  - Requester inputs changing during ACCESS are ignored.
- RESP:
  - The owner's done output is high for exactly this cycle. Next state is IDLE.
  - rdata is valid while done is high and holds until that requester's next completed read. A write leaves rdata unchanged.
  - last_owner is updated to the current owner.
- Timing:
  - Acceptance cycle t is in IDLE. ACCESS occupies t+1 .. t+LATENCY. done is asserted at t+LATENCY+1.
  - Minimum spacing between grants is LATENCY+2 cycles.
- Request handshake: the requester drops or changes req on the clock edge that ends the done cycle. A req still high in the following IDLE cycle is a new access, so back-to-back accesses are legal.
- Outside ACCESS: mem_we is 0, and mem_addr and mem_wdata hold their last values.
- Counter width is $clog2(LATENCY+1). LATENCY = 1 gives a single ACCESS cycle.
- busy is 1 in ACCESS and RESP.
- Default priority is fixed with DATA winning ties, so a continuous d_req starves instruction fetch. This is accepted because data misses stall the pipeline anyway.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both requests are high in IDLE, grant the requester that is not last_owner. Because last_owner resets to 0, the first tie after reset goes to DATA. A single pending request is always granted. No requester waits more than one other access.
- Undefined: fixed DATA priority as above, and last_owner is not implemented.

Test Plan:
- LATENCY=4, i_req with i_addr=0x100, memory returns 0xDEADBEEF -> mem_addr=0x100 in ACCESS, i_done at t+5, i_rdata=0xDEADBEEF, mem_we never 1.
- i_req and d_req rise in the same cycle, with d_we=1, d_addr=0x2004, d_wdata=0x12345678 -> mem_we high for one cycle (t+4) with mem_addr=0x2004; d_done at t+5; INST granted at t+6; i_done at t+11; d_rdata unchanged.
- Both requests held high for 40 cycles -> without macro, six d_done pulses and zero i_done; with MEM_ARB_ROUND_ROBIN_EN, grants alternate D, I, D, I, starting with D.
- d_req read at d_addr=0x303 -> mem_addr=0x300; d_rdata equals mem_rdata sampled at the last ACCESS cycle.
- rst_b pulsed low during the final ACCESS cycle of a write -> mem_we drops asynchronously, busy=0, no d_done; after release a new i_req completes at t+5.
- LATENCY=1, back-to-back d_req reads at 0x10 then 0x14 -> d_done at t+2 and t+5, with correct data each time.
